// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - SAP-1 controller constants: opcodes, T-state indices, control-word layout.
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam int T1 = 0;
  localparam int T2 = 1;
  localparam int T3 = 2;
  localparam int T4 = 3;
  localparam int T5 = 4;
  localparam int T6 = 5;

  // Packed view, MSB first: {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}
  typedef struct packed {
    logic cp;
    logic ep;
    logic lm;
    logic ce;
    logic li;
    logic ei;
    logic la;
    logic ea;
    logic su;
    logic eu;
    logic lb;
    logic lo;
  } cw_t;

endpackage

// File: rtl/sap1_ring.sv
// rtl/sap1_ring.sv - one-hot T-state ring, advances on falling clk; freeze holds, wrap jumps to T1.
module sap1_ring #(
  parameter int T_N = 6
) (
  input  logic           clk,
  input  logic           clr_n,
  input  logic           freeze,
  input  logic           wrap,
  output logic [T_N-1:0] t
);

  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      t <= T_N'(1);
    end else if (freeze) begin
      t <= t;
    end else if (wrap) begin
      t <= T_N'(1);
    end else begin
      t <= {t[T_N-2:0], t[T_N-1]};
    end
  end

endmodule

// File: rtl/sap1_cu.sv
// rtl/sap1_cu.sv - SAP-1 controller-sequencer: ring, halt flag and strobe decode.
// SAP1_VARCYC_EN: wrap the ring to T1 right after each instruction's last useful state.
module sap1_cu
  import sap1_pkg::*;
#(
  parameter int OP_W = 4,
  parameter int T_N  = 6
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic [OP_W-1:0] op,
  output logic [T_N-1:0]  t,
  output logic            cp,
  output logic            ep,
  output logic            lm,
  output logic            ce,
  output logic            li,
  output logic            ei,
  output logic            la,
  output logic            ea,
  output logic            su,
  output logic            eu,
  output logic            lb,
  output logic            lo,
  output logic            hlt
);

  logic halt;
  logic wrap;
  logic is_nop;
  cw_t  cw;

  assign is_nop = !(op inside {OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT});

`ifdef SAP1_VARCYC_EN
  assign wrap = (t[T3] && is_nop) ||
                (t[T4] && op == OP_OUT) ||
                (t[T5] && op == OP_LDA) ||
                (t[T6] && (op == OP_ADD || op == OP_SUB));
`else
  assign wrap = 1'b0;
`endif

  sap1_ring #(.T_N(T_N)) u_ring (
    .clk    (clk),
    .clr_n  (clr_n),
    .freeze (halt),
    .wrap   (wrap),
    .t      (t)
  );

  // Set on the T3->T4 edge so the ring lands on T4 and then freezes there.
  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      halt <= 1'b0;
    end else if (t[T3] && op == OP_HLT) begin
      halt <= 1'b1;
    end
  end

  always_comb begin
    cw = '0;
    if (t[T1]) begin
      cw.ep = 1'b1;
      cw.lm = 1'b1;
    end
    if (t[T2]) cw.cp = 1'b1;
    if (t[T3]) begin
      cw.ce = 1'b1;
      cw.li = 1'b1;
    end
    case (op)
      OP_LDA: begin
        if (t[T4]) begin cw.ei = 1'b1; cw.lm = 1'b1; end
        if (t[T5]) begin cw.ce = 1'b1; cw.la = 1'b1; end
      end
      OP_ADD, OP_SUB: begin
        if (t[T4]) begin cw.ei = 1'b1; cw.lm = 1'b1; end
        if (t[T5]) begin cw.ce = 1'b1; cw.lb = 1'b1; end
        if (t[T6]) begin cw.eu = 1'b1; cw.la = 1'b1; end
        // Subtract mode held across T4..T6 so the adder output is settled by T6.
        cw.su = (op == OP_SUB) && (t[T4] || t[T5] || t[T6]);
      end
      OP_OUT: begin
        if (t[T4]) begin cw.ea = 1'b1; cw.lo = 1'b1; end
      end
      default: ;
    endcase
    if (!clr_n || halt) cw = '0;
  end

  assign {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo} = cw;
  assign hlt = halt & clr_n;

endmodule

// File: tb/tb_sap1_cu.sv
// tb/tb_sap1_cu.sv - scoreboard bench for sap1_cu (directed vectors, posedge-sampled checks).
module tb_sap1_cu;

  localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200, CE = 12'h100;
  localparam logic [11:0] LI = 12'h080, EI = 12'h040, LA = 12'h020, EA = 12'h010;
  localparam logic [11:0] SU = 12'h008, EU = 12'h004, LB = 12'h002, LO = 12'h001;
  localparam logic [11:0] NONE = 12'h000;

`ifdef SAP1_VARCYC_EN
  localparam int L_LDA = 5, L_ALU = 6, L_OUT = 4, L_NOP = 3;
`else
  localparam int L_LDA = 6, L_ALU = 6, L_OUT = 6, L_NOP = 6;
`endif

  typedef struct packed {
    logic [15:0] id;
    logic [5:0]  t;
    logic [11:0] cw;
    logic        hlt;
  } exp_t;

  logic       clk;
  logic       clr_n;
  logic [3:0] op;
  logic [5:0] t;
  logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_push = 0;

  sap1_cu dut (
    .clk(clk), .clr_n(clr_n), .op(op), .t(t),
    .cp(cp), .ep(ep), .lm(lm), .ce(ce), .li(li), .ei(ei), .la(la),
    .ea(ea), .su(su), .eu(eu), .lb(lb), .lo(lo), .hlt(hlt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    exp_t e;
    logic [11:0] cw_act;
    cw_act = {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};
    checks++;
    if (!$onehot0({ep, ce, ei, ea, eu})) begin
      errors++;
      $display("FAIL bus_onehot got %b required at most one bit set", {ep, ce, ei, ea, eu});
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (t !== e.t) begin
        errors++;
        $display("FAIL t id=%0d got %b required %b", e.id, t, e.t);
      end
      checks++;
      if (cw_act !== e.cw) begin
        errors++;
        $display("FAIL strobes id=%0d got %h required %h", e.id, cw_act, e.cw);
      end
      checks++;
      if (hlt !== e.hlt) begin
        errors++;
        $display("FAIL hlt id=%0d got %b required %b", e.id, hlt, e.hlt);
      end
    end
  end

  task automatic push(input logic [5:0] te, input logic [11:0] cwe, input logic he);
    exp_t e;
    e.id  = n_push[15:0];
    e.t   = te;
    e.cw  = cwe;
    e.hlt = he;
    n_push++;
    sb.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    clr_n = 1'b0;
    push(6'b000001, NONE, 1'b0);
    step();
    clr_n = 1'b1;
  endtask

  // op is scrambled during T1/T2 and set to the real opcode at the start of T3.
  task automatic fetch(input logic [3:0] o);
    op = 4'($urandom_range(0, 15));
    push(6'b000001, EP | LM, 1'b0);
    step();
    op = 4'($urandom_range(0, 15));
    push(6'b000010, CP, 1'b0);
    step();
    op = o;
    push(6'b000100, CE | LI, 1'b0);
    step();
  endtask

  task automatic run_instr(input logic [3:0] o, input int len,
                           input logic [11:0] c4, input logic [11:0] c5, input logic [11:0] c6);
    logic [11:0] c [3];
    logic [5:0]  ts;
    c[0] = c4; c[1] = c5; c[2] = c6;
    fetch(o);
    for (int k = 0; k < len - 3; k++) begin
      ts = 6'b001000 << k;
      push(ts, c[k], 1'b0);
      step();
    end
  endtask

  initial begin
    clr_n = 1'b0;
    op    = 4'b0000;
    step();
    push(6'b000001, NONE, 1'b0);
    step();
    clr_n = 1'b1;

    run_instr(4'b0000, L_LDA, EI | LM, CE | LA, NONE);
    run_instr(4'b0001, L_ALU, EI | LM, CE | LB, EU | LA);
    run_instr(4'b0010, L_ALU, EI | LM | SU, CE | LB | SU, EU | LA | SU);
    run_instr(4'b1110, L_OUT, EA | LO, NONE, NONE);
    run_instr(4'b0101, L_NOP, NONE, NONE, NONE);
    run_instr(4'b0000, L_LDA, EI | LM, CE | LA, NONE);

    // Reset in the middle of T5 of an ADD.
    fetch(4'b0001);
    push(6'b001000, EI | LM, 1'b0);
    step();
    clr_n = 1'b0;
    push(6'b000001, NONE, 1'b0);
    step();
    push(6'b000001, NONE, 1'b0);
    step();
    clr_n = 1'b1;
    run_instr(4'b0001, L_ALU, EI | LM, CE | LB, EU | LA);

    for (int i = 0; i < 100; i++) begin
      op = 4'($urandom_range(0, 15));
      step();
    end
    reset_pulse();

    fetch(4'b1111);
    for (int i = 0; i < 20; i++) begin
      op = 4'b1111;
      push(6'b001000, NONE, 1'b1);
      step();
    end
    reset_pulse();
    run_instr(4'b1110, L_OUT, EA | LO, NONE, NONE);
    run_instr(4'b0010, L_ALU, EI | LM | SU, CE | LB | SU, EU | LA | SU);

    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries left required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
